// File: rtl/pong_vga_renderer.sv
// rtl/pong_vga_renderer.sv - VGA timing, per-frame game-state snapshot and pixel painter for pong
module pong_vga_renderer #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIP_SIZE  = 8,
  parameter int PIP_PITCH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [9:0] ball_pos_x,
  input  logic signed [9:0] ball_pos_y,
  input  logic [9:0]        player_left_pos,
  input  logic [9:0]        player_right_pos,
  input  logic [3:0]        score_left,
  input  logic [3:0]        score_right,
  input  logic [9:0]        paddle_width,
  input  logic [9:0]        paddle_height,
  input  logic [9:0]        paddle_offset,
  input  logic [9:0]        ball_size,
  input  logic [9:0]        border_top,
  input  logic [9:0]        border_bottom,
  input  logic [9:0]        border_left,
  input  logic [9:0]        border_right,
  input  logic              game_over_signal,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        rgb,
  output logic              frame_tick,
  output logic [9:0]        hcount,
  output logic [9:0]        vcount
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACTEND = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // 12-bit signed region math: no sum of 10-bit operands can wrap into view
  typedef logic signed [11:0] s12_t;

  logic [DIV_W-1:0] div;
  logic             pix_en;
  logic [9:0]       h, v;
  logic             h_last, v_last, frame_start;

  logic signed [9:0] s_ball_x, s_ball_y;
  logic [9:0] s_pl, s_pr, s_pw, s_ph, s_po, s_bs, s_bt, s_bb, s_bl, s_br;
  logic [3:0] s_sl, s_sr;
  logic       s_go;

  assign pix_en      = (div == DIV_W'(CLK_DIV - 1));
  assign h_last      = (h == H_LAST);
  assign v_last      = (v == V_LAST);
  assign frame_start = pix_en && h_last && (v == V_ACTEND);

  // Pixel-enable divider, restarting from zero on reset
  always_ff @(posedge clk) begin
    if (!reset)      div <= '0;
    else if (pix_en) div <= '0;
    else             div <= div + 1'b1;
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Game-state snapshot taken at the start of vertical blank
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_ball_x <= '0; s_ball_y <= '0; s_pl <= '0; s_pr <= '0;
      s_pw <= '0; s_ph <= '0; s_po <= '0; s_bs <= '0;
      s_bt <= '0; s_bb <= '0; s_bl <= '0; s_br <= '0;
      s_sl <= '0; s_sr <= '0; s_go <= 1'b0;
    end else if (frame_start) begin
      s_ball_x <= ball_pos_x;      s_ball_y <= ball_pos_y;
      s_pl <= player_left_pos;     s_pr <= player_right_pos;
      s_pw <= paddle_width;        s_ph <= paddle_height;
      s_po <= paddle_offset;       s_bs <= ball_size;
      s_bt <= border_top;          s_bb <= border_bottom;
      s_bl <= border_left;         s_br <= border_right;
      s_sl <= score_left;          s_sr <= score_right;
      s_go <= game_over_signal;
    end
  end

  s12_t x, y, bx0, bx1, by0, by1, lx0, lx1, rx0, rx1, ly1, ry1, py0, py1;
  s12_t bt, bb, bl, br, pl, pr;
  logic in_ball, in_pad, in_pip, in_border, pip_row;
  logic [7:0] pixel;

  // Region membership and colour priority for the current raster position
  always_comb begin
    x   = s12_t'({2'b00, h});
    y   = s12_t'({2'b00, v});
    bt  = s12_t'({2'b00, s_bt});
    bb  = s12_t'({2'b00, s_bb});
    bl  = s12_t'({2'b00, s_bl});
    br  = s12_t'({2'b00, s_br});
    pl  = s12_t'({2'b00, s_pl});
    pr  = s12_t'({2'b00, s_pr});
    bx0 = s12_t'({{2{s_ball_x[9]}}, s_ball_x});
    by0 = s12_t'({{2{s_ball_y[9]}}, s_ball_y});
    bx1 = bx0 + s12_t'({2'b00, s_bs}) - 12'sd1;
    by1 = by0 + s12_t'({2'b00, s_bs}) - 12'sd1;
    lx0 = bl + s12_t'({2'b00, s_po}) + 12'sd1;
    lx1 = bl + s12_t'({2'b00, s_po}) + s12_t'({2'b00, s_pw});
    rx0 = br - s12_t'({2'b00, s_po}) - s12_t'({2'b00, s_pw});
    rx1 = br - s12_t'({2'b00, s_po}) - 12'sd1;
    ly1 = pl + s12_t'({2'b00, s_ph}) - 12'sd1;
    ry1 = pr + s12_t'({2'b00, s_ph}) - 12'sd1;
    py0 = bt - s12_t'(PIP_SIZE + 2);
    py1 = bt - 12'sd3;

    in_ball = (x >= bx0) && (x <= bx1) && (y >= by0) && (y <= by1);
    in_pad  = ((x >= lx0) && (x <= lx1) && (y >= pl) && (y <= ly1)) ||
              ((x >= rx0) && (x <= rx1) && (y >= pr) && (y <= ry1));
    in_border = (((y == bt) || (y == bb)) && (x >= bl) && (x <= br)) ||
                (((x == bl) || (x == br)) && (y >= bt) && (y <= bb));
    pip_row = (y >= py0) && (y <= py1);

    // At most ten pips per side; the loop bound clamps larger scores
    in_pip = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (pip_row && (k < int'(s_sl)) &&
          (x >= bl + s12_t'(k * PIP_PITCH)) &&
          (x <= bl + s12_t'(k * PIP_PITCH + PIP_SIZE - 1)))
        in_pip = 1'b1;
      if (pip_row && (k < int'(s_sr)) &&
          (x >= br - s12_t'(k * PIP_PITCH + PIP_SIZE - 1)) &&
          (x <= br - s12_t'(k * PIP_PITCH)))
        in_pip = 1'b1;
    end

    if (in_ball)        pixel = 8'hE0;
    else if (in_pad)    pixel = 8'h1C;
    else if (in_pip)    pixel = 8'hFC;
    else if (in_border) pixel = 8'hFF;
    else                pixel = s_go ? 8'h02 : 8'h00;
  end

  // Registered outputs, all one pixel behind the counters so they stay aligned
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= 8'h00;
      frame_tick <= 1'b0;
      hcount     <= '0;
      vcount     <= '0;
    end else begin
      frame_tick <= frame_start;
      if (pix_en) begin
        hcount <= h;
        vcount <= v;
        hsync  <= !((h >= HS_START) && (h <= HS_END));
        vsync  <= !((v >= VS_START) && (v <= VS_END));
        rgb    <= ((h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE))) ? pixel : 8'h00;
      end
    end
  end
endmodule
